// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel window scheduler: pixel/window geometry,
// line-buffer count and the scheduler FSM state encoding.
package sobel_pkg;

  localparam int PIX_W     = 8;
  localparam int KSIZE     = 3;
  localparam int WIN_W     = KSIZE * KSIZE * PIX_W;
  localparam int NUM_LINES = 4;
  localparam int SEL_W     = $clog2(NUM_LINES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Three horizontal taps of one line: index 0 = left (c-1), 1 = centre, 2 = right (c+1).
  typedef logic [KSIZE-1:0][PIX_W-1:0] taps_t;

endpackage : sobel_pkg

// File: rtl/sobel_window_sched_line_buffer.sv
// One image line of pixels with a single write port and a combinational 3-tap read
// around a centre column, replicating the edge pixel at both line ends.
module line_buffer
  import sobel_pkg::*;
#(
  parameter int P_IMG_WIDTH = 512,
  localparam int COL_W      = $clog2(P_IMG_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [COL_W-1:0] i_wr_col,
  input  logic [PIX_W-1:0] i_data,
  input  logic [COL_W-1:0] i_rd_col,
  output taps_t            o_taps
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(P_IMG_WIDTH - 1);

  logic [PIX_W-1:0] mem [P_IMG_WIDTH];
  logic [COL_W-1:0] col_l;
  logic [COL_W-1:0] col_r;

  // NOTE: the pixel array has no reset; contents are only read after being written,
  // and leaving it out keeps it mappable to plain storage instead of reset flops.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_wr_col] <= i_data;
  end

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    col_l     = (i_rd_col == '0)       ? i_rd_col : i_rd_col - 1'b1;
    col_r     = (i_rd_col == LAST_COL) ? i_rd_col : i_rd_col + 1'b1;
    o_taps[0] = mem[col_l];
    o_taps[1] = mem[i_rd_col];
    o_taps[2] = mem[col_r];
  end

endmodule : line_buffer

// File: rtl/sobel_window_sched.sv
// Sobel front-end: writes the pixel stream into four rotating line buffers and issues
// one registered 3x3 window per cycle, gated by credits from the downstream result FIFO.
module sobel_window_sched
  import sobel_pkg::*;
#(
  parameter int P_IMG_WIDTH = 512,
  parameter int P_CREDITS   = 16,
  localparam int CRD_W      = $clog2(P_CREDITS + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_data,
  output logic             o_ready,
  output logic             o_win_valid,
  output logic [WIN_W-1:0] o_win_data,
  input  logic             i_result_pop,
  output logic [CRD_W-1:0] o_credits
);

  localparam int COL_W      = $clog2(P_IMG_WIDTH);
  localparam int STORED_MAX = NUM_LINES * P_IMG_WIDTH;
  localparam int STO_W      = $clog2(STORED_MAX + 1);

  localparam logic [COL_W-1:0] LAST_COL    = COL_W'(P_IMG_WIDTH - 1);
  localparam logic [STO_W-1:0] LINE_STO    = STO_W'(P_IMG_WIDTH);
  localparam logic [STO_W-1:0] READ_LVL    = STO_W'(KSIZE * P_IMG_WIDTH);
  localparam logic [STO_W-1:0] FULL_LVL    = STO_W'(STORED_MAX);
  localparam logic [CRD_W-1:0] CREDITS_MAX = CRD_W'(P_CREDITS);

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   wr_sel;
  logic [SEL_W-1:0]   rd_sel;
  logic [COL_W-1:0]   wr_col;
  logic [COL_W-1:0]   rd_col;
  logic [STO_W-1:0]   stored;
  logic [STO_W-1:0]   stored_d;
  logic [CRD_W-1:0]   credits;
  logic               accept;
  logic               issue;
  logic               line_done;
  logic               pop_ok;
  taps_t              taps [NUM_LINES];
  logic [SEL_W-1:0]   row_sel;
  logic [WIN_W-1:0]   window;

  assign o_ready   = (stored < FULL_LVL);
  assign accept    = i_valid && o_ready;
  assign pop_ok    = i_result_pop && (credits != CREDITS_MAX);
  assign o_credits = credits;

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (stored >= READ_LVL) state_d = READ;
      READ:    if (line_done)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue     = (state_q == READ) && (credits != '0);
    line_done = issue && (rd_col == LAST_COL);
  end

  // ---------------- pointers, occupancy and credits ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_sel <= '0;
      wr_col <= '0;
    end else if (accept) begin
      if (wr_col == LAST_COL) begin
        wr_col <= '0;
        wr_sel <= wr_sel + 1'b1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_sel <= '0;
      rd_col <= '0;
    end else if (issue) begin
      if (line_done) begin
        rd_col <= '0;
        rd_sel <= rd_sel + 1'b1;
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  // NOTE: blocking assignments here build the next value step by step inside one
  // combinational evaluation; the register below samples it with a non-blocking update.
  always_comb begin
    stored_d = stored;
    if (accept)    stored_d = stored_d + 1'b1;
    if (line_done) stored_d = stored_d - LINE_STO;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) stored <= '0;
    else          stored <= stored_d;
  end

  // A pop arriving while the counter is already full is dropped rather than wrapping.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      credits <= CREDITS_MAX;
    end else begin
      case ({issue, pop_ok})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // ---------------- line buffers and window assembly ----------------
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    line_buffer #(
      .P_IMG_WIDTH(P_IMG_WIDTH)
    ) u_line_buffer (
      .i_clk   (i_clk),
      .i_we    (accept && (wr_sel == SEL_W'(i))),
      .i_wr_col(wr_col),
      .i_data  (i_data),
      .i_rd_col(rd_col),
      .o_taps  (taps[i])
    );
  end

  // Row 0 is the oldest of the three lines being read; byte k = row*3 + col.
  always_comb begin
    window  = '0;
    row_sel = '0;
    for (int r = 0; r < KSIZE; r++) begin
      row_sel = rd_sel + SEL_W'(r);
      for (int c = 0; c < KSIZE; c++) begin
        window[(r*KSIZE + c)*PIX_W +: PIX_W] = taps[row_sel][c];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_win_valid <= 1'b0;
      o_win_data  <= '0;
    end else begin
      o_win_valid <= issue;
      if (issue) o_win_data <= window;
    end
  end

endmodule : sobel_window_sched

// File: tb/tb_sobel_window_sched.sv
// Directed bench for sobel_window_sched with a narrow 8-pixel line and 4 credits;
// every expected window is built from the pixel = line*16 + col pattern.
module tb_sobel_window_sched;
  import sobel_pkg::*;

  localparam int W     = 8;
  localparam int C     = 4;
  localparam int CRD_W = $clog2(C + 1);

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_valid = 1'b0;
  logic [PIX_W-1:0] i_data = '0;
  logic             i_result_pop = 1'b0;
  logic             o_ready;
  logic             o_win_valid;
  logic [WIN_W-1:0] o_win_data;
  logic [CRD_W-1:0] o_credits;

  int n_vec = 0;
  int n_bad = 0;
  int n_acc = 0;
  int cyc   = 0;
  logic [WIN_W-1:0] win_q [$];
  int               win_cyc [$];

  sobel_window_sched #(
    .P_IMG_WIDTH(W),
    .P_CREDITS  (C)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_win_valid (o_win_valid),
    .o_win_data  (o_win_data),
    .i_result_pop(i_result_pop),
    .o_credits   (o_credits)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_win_valid) begin
      win_q.push_back(o_win_data);
      win_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix(input int line, input int col);
    return PIX_W'(line * 16 + col);
  endfunction

  function automatic logic [WIN_W-1:0] exp_win(input int top, input int c);
    logic [WIN_W-1:0] w;
    int cc;
    w = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int k = 0; k < KSIZE; k++) begin
        cc = c + k - 1;
        if (cc < 0)     cc = 0;
        if (cc > W - 1) cc = W - 1;
        w[(r*KSIZE + k)*PIX_W +: PIX_W] = pix(top + r, cc);
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid      = 1'b0;
    i_result_pop = 1'b0;
    i_reset      = 1'b0;
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    win_q.delete();
    win_cyc.delete();
    n_acc = 0;
  endtask

  // Offers one pixel and waits (bounded) for the handshake; i_valid stays high afterwards.
  task automatic push_pixel(input logic [PIX_W-1:0] d);
    logic rdy;
    i_valid = 1'b1;
    i_data  = d;
    for (int t = 0; t < 100; t++) begin
      rdy = o_ready;
      tick();
      if (rdy) begin
        n_acc++;
        return;
      end
    end
    check("push_timeout", 0, 1);
  endtask

  task automatic push_line(input int line);
    for (int col = 0; col < W; col++) push_pixel(pix(line, col));
  endtask

  task automatic check_win(input string tag, input int idx, input logic [WIN_W-1:0] exp);
    if (idx < win_q.size()) check(tag, win_q[idx], exp);
    else                    check({tag, "_missing"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic rdy;
    int   k;
    bit   seen;

    // ---- reset values ----
    do_reset();
    check("rst_ready",   o_ready, 1);
    check("rst_win_vld", o_win_valid, 0);
    check("rst_win_dat", o_win_data, 0);
    check("rst_credits", o_credits, C);

    // ---- fill threshold, pulse train, window contents (pops keep credits up) ----
    i_result_pop = 1'b1;
    push_line(0);
    push_line(1);
    for (int col = 0; col < W - 1; col++) push_pixel(pix(2, col));
    i_valid = 1'b0;
    repeat (5) tick();
    check("fill23_no_win", win_q.size(), 0);
    push_pixel(pix(2, W - 1));
    i_valid = 1'b0;
    repeat (15) tick();
    check("fill24_pulses", win_q.size(), 8);
    if (win_q.size() >= 8) check("pulse_spacing", win_cyc[7] - win_cyc[0], 7);
    check_win("win_c0_hand", 0, 72'h212020111010010000);
    for (int c = 0; c < W; c++) check_win($sformatf("win_l0_c%0d", c), c, exp_win(0, c));
    i_result_pop = 1'b0;
    tick();
    check("credits_refilled", o_credits, C);

    // ---- credit stall: no pops -> 4 windows, then one pop -> one more ----
    do_reset();
    push_line(0);
    push_line(1);
    push_line(2);
    i_valid = 1'b0;
    repeat (15) tick();
    check("stall_count", win_q.size(), 4);
    check("stall_credits", o_credits, 0);
    i_result_pop = 1'b1;
    tick();
    check("pop_return", o_credits, 1);
    i_result_pop = 1'b0;
    repeat (8) tick();
    check("one_more_count", win_q.size(), 5);
    check("one_more_credits", o_credits, 0);
    check_win("one_more_data", 4, exp_win(0, 4));

    // ---- backpressure: credits stay 0, valid held high ----
    k = 0;
    for (int t = 0; t < 12; t++) begin
      i_valid = 1'b1;
      i_data  = (k < W) ? pix(3, k) : pix(4, k - W);
      rdy     = o_ready;
      tick();
      if (rdy) k++;
    end
    check("bp_accepted", k, 8);
    check("bp_ready_low", o_ready, 0);
    i_valid = 1'b0;

    // Release with three pops; the second and third coincide with issues.
    i_result_pop = 1'b1;
    tick();
    check("release_pop_only", o_credits, 1);
    tick();
    check("pop_in_issue", o_credits, 1);
    tick();
    i_result_pop = 1'b0;
    repeat (6) tick();
    check("release_count", win_q.size(), 8);
    check("ready_after_line", o_ready, 1);
    for (int c = 5; c < W; c++) check_win($sformatf("release_c%0d", c), c, exp_win(0, c));

    // Next lines read rotated buffers; line 4 lands in the first buffer again.
    i_result_pop = 1'b1;
    for (int col = 1; col < W; col++) begin
      if (col == 1) push_pixel(pix(4, 0));
      push_pixel(pix(4, col));
    end
    i_valid = 1'b0;
    repeat (40) tick();
    check("rot_count", win_q.size(), 24);
    check_win("rot_l1_c0", 8,  exp_win(1, 0));
    check_win("rot_l1_c7", 15, exp_win(1, 7));
    check_win("rot_l2_c0", 16, exp_win(2, 0));
    check_win("rot_l2_c7", 23, exp_win(2, 7));
    i_result_pop = 1'b0;

    // ---- accept in the same cycle as line completion ----
    do_reset();
    i_result_pop = 1'b1;
    push_line(0);
    push_line(1);
    push_line(2);
    i_valid = 1'b0;
    repeat (3) tick();
    seen = 1'b0;
    for (int col = 0; col < W; col++) begin
      push_pixel(pix(3, col));
      if (!seen && o_win_valid && win_q.size() == 7) begin
        seen = 1'b1;
        check("stored_acc_and_done", dut.stored, WIN_W'(n_acc - W));
      end
    end
    i_valid = 1'b0;
    check("acc_done_overlap_seen", seen, 1);

    // ---- reset in the middle of a read line ----
    do_reset();
    i_result_pop = 1'b1;
    push_line(0);
    push_line(1);
    push_line(2);
    i_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      tick();
      if (o_win_valid && win_q.size() == 2) seen = 1'b1;
    end
    check("mid_read_reached", seen, 1);
    #2;
    i_reset = 1'b0;
    #1;
    check("midrst_win_vld", o_win_valid, 0);
    check("midrst_ready",   o_ready, 1);
    check("midrst_credits", o_credits, C);
    check("midrst_win_dat", o_win_data, 0);
    tick();
    i_reset = 1'b1;
    tick();
    win_q.delete();
    win_cyc.delete();
    push_line(10);
    push_line(11);
    push_line(12);
    i_valid = 1'b0;
    repeat (15) tick();
    check("refill_count", win_q.size(), 8);
    check_win("refill_c0", 0, exp_win(10, 0));
    check_win("refill_c7", 7, exp_win(10, 7));
    i_result_pop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_sobel_window_sched
